// File: rtl/ds_pkg.sv
// Shared types and helpers for the down_sampler block: FSM state encoding
// and the width rule for the slot counter / phase select.
package ds_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } ds_state_t;

   // A decimation factor of 1 still needs a 1-bit phase port.
   function automatic int cnt_width(input int l);
      return (l > 1) ? $clog2(l) : 1;
   endfunction

endpackage

// File: rtl/down_sampler_cnt.sv
// Slot counter for down_sampler: tracks the input slot within a frame,
// holds the clamped phase select and flags the slot that produces output.
module down_sampler_cnt
   import ds_pkg::*;
#(
   parameter int L   = 8,
   parameter int CW  = cnt_width(L),
   parameter bit AVG = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          sync,
   input  logic [CW-1:0] phase,
   input  logic          din_valid,
   output logic          strobe
);

   localparam logic [CW-1:0] LAST = CW'(L - 1);

   logic [CW-1:0] count;
   logic [CW-1:0] phase_reg;
   logic [CW-1:0] phase_clamped;
   logic [CW-1:0] slot;
   logic [CW-1:0] sel;
   logic          adv;

   // A sync cycle is slot 0 and compares against the phase being loaded now.
   always_comb begin
      phase_clamped = (phase > LAST) ? LAST : phase;
      slot          = sync ? '0 : count;
      sel           = sync ? phase_clamped : phase_reg;
      adv           = en & din_valid;
      strobe        = AVG ? (adv & (slot == LAST)) : (adv & (slot == sel));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         phase_reg <= '0;
      end else if (!en) begin
         count     <= '0;
         phase_reg <= '0;
      end else begin
         if (sync)
            phase_reg <= phase_clamped;
         if (adv)
            count <= (slot == LAST) ? '0 : slot + 1'b1;
         else if (sync)
            count <= '0;
      end
   end

endmodule

// File: rtl/down_sampler.sv
// Integer down-sampler: keeps one selected slot out of every L valid samples.
// Define DOWN_SAMPLER_AVG_EN to output the mean of each L-sample frame instead.
module down_sampler
   import ds_pkg::*;
#(
   parameter int L     = 8,
   parameter int width = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    sync,
   input  logic [cnt_width(L)-1:0] phase,
   input  logic signed [width-1:0] din,
   input  logic                    din_valid,
   output logic signed [width-1:0] dout,
   output logic                    dout_valid,
   output logic                    locked
);

   localparam int CW = cnt_width(L);

   ds_state_t               state;
   logic                    take;
   logic signed [width-1:0] sample;

`ifdef DOWN_SAMPLER_AVG_EN
   localparam bit AVG   = 1'b1;
   localparam int SH    = $clog2(L);
   localparam int ACC_W = width + SH;

   if ((L < 1) || ((L & (L - 1)) != 0)) begin : g_bad_l
      $error("down_sampler: averaging requires L to be a power of two");
   end

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum_n;

   // The sync sample opens a fresh frame, so it never adds to the old sum.
   assign sum_n  = (sync ? '0 : acc) + ACC_W'(din);
   assign sample = width'(sum_n >>> SH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (!en)
         acc <= '0;
      else if (din_valid)
         acc <= take ? '0 : sum_n;
      else if (sync)
         acc <= '0;
   end
`else
   localparam bit AVG = 1'b0;

   assign sample = din;
`endif

   down_sampler_cnt #(
      .L   (L),
      .CW  (CW),
      .AVG (AVG)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sync      (sync),
      .phase     (phase),
      .din_valid (din_valid),
      .strobe    (take)
   );

   // locked follows the LOCK state; dout holds its value whenever no sample is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dout       <= '0;
         dout_valid <= 1'b0;
         locked     <= 1'b0;
      end else if (!en) begin
         state      <= IDLE;
         dout_valid <= 1'b0;
         locked     <= 1'b0;
      end else begin
         dout_valid <= take;
         if (take)
            dout <= sample;
         if (take) begin
            state  <= LOCK;
            locked <= 1'b1;
         end else if (sync || state == IDLE) begin
            state  <= ACQ;
            locked <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_down_sampler.sv
// Directed bench for down_sampler at L=8, L=4 and L=1 with a strobe scoreboard.
// Expected output samples and their cycle are queued as stimulus is driven.
module tb_down_sampler;

   localparam int W = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                sync;
   logic                din_valid;
   logic signed [W-1:0] din;
   logic                en8, en4, en1;
   logic [2:0]          ph8;
   logic [1:0]          ph4;
   logic [0:0]          ph1;
   logic signed [W-1:0] dout8, dout4, dout1;
   logic                dv8, dv4, dv1;
   logic                lk8, lk4, lk1;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int vals [5]   = '{10, 20, 30, 40, 50};

   typedef struct {
      int id;
      int value;
      int cyc;
   } exp_t;

   exp_t sb[$];

   down_sampler #(.L(8), .width(W)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .sync(sync), .phase(ph8),
      .din(din), .din_valid(din_valid), .dout(dout8), .dout_valid(dv8), .locked(lk8)
   );

   down_sampler #(.L(4), .width(W)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .sync(sync), .phase(ph4),
      .din(din), .din_valid(din_valid), .dout(dout4), .dout_valid(dv4), .locked(lk4)
   );

   down_sampler #(.L(1), .width(W)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .sync(sync), .phase(ph1),
      .din(din), .din_valid(din_valid), .dout(dout1), .dout_valid(dv1), .locked(lk1)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Queue an output expected on the cycle after the coming clock edge.
   task automatic expect_out(input int id, input int value);
      sb.push_back('{id, value, cyc + 1});
   endtask

   task automatic step(input logic s, input logic v, input int d);
      sync      = s;
      din_valid = v;
      din       = W'(d);
      @(posedge clk);
      #1;
      sync      = 1'b0;
      din_valid = 1'b0;
   endtask

   task automatic take_strobe(input int id, input logic signed [W-1:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         check($sformatf("spurious strobe dut%0d queue depth", id), sb.size(), 1);
      end else begin
         e = sb.pop_front();
         check("strobe source", id, e.id);
         check($sformatf("dout dut%0d", id), d, e.value);
         check($sformatf("strobe cycle dut%0d", id), cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         check($sformatf("missing strobe dut%0d cycle", sb[0].id), cyc, sb[0].cyc);
         sb.delete(0);
      end
      if (rst_n) begin
         if (dv8) take_strobe(8, dout8);
         if (dv4) take_strobe(4, dout4);
         if (dv1) take_strobe(1, dout1);
      end
   end

   initial begin
      rst_n = 1'b0; sync = 1'b0; din_valid = 1'b0; din = '0;
      en8 = 1'b0; en4 = 1'b0; en1 = 1'b0;
      ph8 = '0; ph4 = '0; ph1 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset dout", dout8, 0);
      check("reset dout_valid", dv8, 0);
      check("reset locked", lk8, 0);
      rst_n = 1'b1;

`ifdef DOWN_SAMPLER_AVG_EN
      en4 = 1'b1;
      step(0, 1, 4);
      step(0, 1, 8);
      step(0, 1, -4);
      expect_out(4, 5);
      step(0, 1, 12);
      check("avg locked", lk4, 1);
      step(0, 0, 0);
      check("avg single strobe", dv4, 0);
      en4 = 1'b0;
      step(0, 0, 0);
`else
      // L=8 ramp from the first enabled cycle, phase 0
      en8 = 1'b1;
      check("locked before first strobe", lk8, 0);
      for (int i = 0; i < 24; i++) begin
         if (i % 8 == 0) expect_out(8, i);
         step(0, 1, i);
         if (i == 0) check("locked after first strobe", lk8, 1);
      end
      en8 = 1'b0;
      step(0, 1, 99);
      check("en low clears locked", lk8, 0);
      check("en low holds dout", dout8, 16);

      // sync with phase 3 on din=100, then phase 7 on din=200
      en8 = 1'b1;
      expect_out(8, 7);
      step(0, 1, 7);
      step(0, 1, 8);
      check("locked before sync", lk8, 1);
      ph8 = 3'd3;
      step(1, 1, 100);
      check("sync clears locked", lk8, 0);
      for (int i = 101; i <= 111; i++) begin
         if (i == 103 || i == 111) expect_out(8, i);
         step(0, 1, i);
         if (i == 102) check("locked low until strobe", lk8, 0);
         if (i == 103) check("locked at strobe after sync", lk8, 1);
      end
      ph8 = 3'd7;
      step(1, 1, 200);
      for (int i = 201; i <= 207; i++) begin
         if (i == 207) expect_out(8, i);
         step(0, 1, i);
      end
      en8 = 1'b0;
      step(0, 0, 0);

      // L=4 with din_valid toggling; invalid cycles carry junk
      en4 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 0 || k == 4) expect_out(4, vals[k]);
         step(0, 1, vals[k]);
         if (k < 4) step(0, 0, 999);
         if (k == 2) begin
            check("dout held between strobes", dout4, 10);
            check("dout_valid low between strobes", dv4, 0);
         end
      end
      en4 = 1'b0;
      step(0, 0, 0);

      // asynchronous reset at slot 5 of an L=8 frame
      en8 = 1'b1;
      expect_out(8, 300);
      for (int i = 0; i < 5; i++) step(0, 1, 300 + i);
      rst_n = 1'b0;
      #1;
      check("async reset dout", dout8, 0);
      check("async reset dout_valid", dv8, 0);
      check("async reset locked", lk8, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_out(8, 555);
      step(0, 1, 555);
      step(0, 1, 556);
      en8 = 1'b0;
      step(0, 0, 0);

      // L=1: out-of-range phase clamps to 0, every valid sample passes
      en1 = 1'b1;
      ph1 = 1'b1;
      expect_out(1, -5);
      step(1, 1, -5);
      check("L1 locked after sync sample", lk1, 1);
      expect_out(1, -6);
      step(0, 1, -6);
      step(0, 0, 7);
      expect_out(1, 42);
      step(0, 1, 42);
      step(1, 0, 0);
      check("L1 sync clears locked", lk1, 0);
      expect_out(1, 9);
      step(0, 1, 9);
      check("L1 locked again", lk1, 1);
      en1 = 1'b0;
      step(0, 0, 0);
`endif

      repeat (3) step(0, 0, 0);
      check("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/down_sampler.md
DOWN_SAMPLER -- requirements
Module: down_sampler

Interface
REQ-001 SHALL have parameter L, default 8, decimation factor (integer, >=1).
REQ-002 SHALL have parameter width, default 20, sample width in bits (two's complement).
REQ-003 SHALL have port clk  input  1  single clock, rising edge, runs at input sample rate.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  block enable; low forces IDLE.
REQ-006 SHALL have port sync  input  1  single-cycle pulse; restarts decimation phase.
REQ-007 SHALL have port phase  input  max($clog2(L),1)  selected input slot, sampled only at sync.
REQ-008 SHALL have port din  input  width  signed input sample.
REQ-009 SHALL have port din_valid  input  1  din qualifier.
REQ-010 SHALL have port dout  output  width  signed decimated sample, registered.
REQ-011 SHALL have port dout_valid  output  1  one-cycle strobe per output sample.
REQ-012 SHALL have port locked  output  1  high once the first output has been produced since the last sync or enable.

Function
REQ-013 SHALL implement FSM IDLE -> ACQ (en=1) -> LOCK (first dout_valid) -> IDLE (en=0, from any state).
REQ-014 SHALL, in IDLE, hold slot counter at 0, phase register at 0, dout_valid=0, locked=0; dout keeps its last value.
REQ-015 SHALL advance slot counter only on cycles with en=1 and din_valid=1; wrap L-1 -> 0 for any L.
REQ-016 SHALL, without DOWN_SAMPLER_AVG_EN, capture din when din_valid=1 and count==phase_reg; dout updates and dout_valid=1 exactly one cycle later.
REQ-017 SHALL hold dout between strobes (no zero insertion); dout_valid low otherwise.
REQ-018 SHALL, on sync=1 (en=1), load phase_reg<=phase, treat the current cycle as slot 0, enter ACQ, clear locked.
REQ-019 SHALL, with sync and din_valid both high, count that sample as slot 0 (captured if phase=0), next valid is slot 1.
REQ-020 SHALL clamp phase>=L to L-1 when loaded.
REQ-021 SHALL, with L=1, pass every valid sample with 1-cycle latency; sync still clears/sets locked.
REQ-022 SHALL, on en falling mid-frame, discard partial state; no dout_valid in the cycle after en goes low.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set FSM=IDLE, counter=0, phase_reg=0, dout=0, dout_valid=0, locked=0, accumulator=0.
REQ-024 SHALL require no sync after reset; first en=1 starts at slot 0 with phase_reg=0.

Configuration
REQ-025 SHALL support macro DOWN_SAMPLER_AVG_EN: when defined, dout = arithmetic-right-shift by log2(L) of the sum of L consecutive valid samples (slots 0..L-1, phase ignored), accumulator width+$clog2(L) bits, strobe one cycle after slot L-1; L must be a power of two (elaboration error otherwise).
REQ-026 SHALL, when DOWN_SAMPLER_AVG_EN is undefined, contain no accumulator logic and behave per REQ-016.
REQ-027 SHALL, with DOWN_SAMPLER_AVG_EN, clear the accumulator on sync, en low and reset.

Structure
REQ-028 SHALL place FSM state typedef (IDLE, ACQ, LOCK) and counter-width constant function in shared package ds_pkg.
REQ-029 SHALL implement slot counter with phase compare/clamp as sub-module down_sampler_cnt; FSM, datapath and optional accumulator in the top.

Verification
REQ-030 SHALL cover: L=8, en=1, phase=0, din_valid always 1, din=ramp 0,1,2,... -> dout=0,8,16,...; dout_valid every 8th cycle; locked high after first strobe.
REQ-031 SHALL cover: sync with phase=3 coincident with din=100, then ramp 101.. -> first dout=103, then 111; locked low from sync to first strobe.
REQ-032 SHALL cover: din_valid toggling 1/0, L=4, phase=0, din=10,20,30,40,50 on valid cycles -> dout=10 then 50; invalid cycles do not advance.
REQ-033 SHALL cover: rst_n asserted mid-frame at slot 5 -> all outputs 0 immediately; after release with en=1, first dout is first valid din.
REQ-034 SHALL cover: DOWN_SAMPLER_AVG_EN, L=4, din=4,8,-4,12 -> dout=5, one strobe; phase=7 at L=8 without macro -> clamped, captures slot 7.
